// File: rtl/deck_dealer.sv
// deck_dealer: deals opening hands from a shuffled deck, flips the first
// discard, then serves 1..4 card draw bursts over a valid/ready stream.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_deck, i_deck_valid shuffled deck array and its valid flag
//   i_start              pulse: begin a new deal (IDLE only)
//   i_num_players        player count, clamped to 2..MAX_PLAYERS
//   i_draw_req           pulse: draw burst request (SERVE only)
//   i_draw_player        destination player of the burst
//   i_draw_cnt           burst length, 0 ignored, >4 clamps to 4
//   i_card_ready         consumer accepts o_card
//   o_card, o_card_valid card stream payload and valid
//   o_player, o_last     destination player, final card of deal/burst
//   o_top_card           first discard card
//   o_top_valid          o_top_card valid
//   o_busy               dealing, flipping or drawing
//   o_empty              deck exhausted
//   o_short              pulse: request cut short by exhaustion
//   o_remaining          cards left in deck
module deck_dealer #(
  parameter int NUM_CARDS   = 108,
  parameter int HAND_SIZE   = 7,
  parameter int MAX_PLAYERS = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_deck [NUM_CARDS-1:0],
  input  logic       i_deck_valid,
  input  logic       i_start,
  input  logic [2:0] i_num_players,
  input  logic       i_draw_req,
  input  logic [1:0] i_draw_player,
  input  logic [2:0] i_draw_cnt,
  input  logic       i_card_ready,
  output logic [5:0] o_card,
  output logic       o_card_valid,
  output logic [1:0] o_player,
  output logic       o_last,
  output logic [5:0] o_top_card,
  output logic       o_top_valid,
  output logic       o_busy,
  output logic       o_empty,
  output logic       o_short,
  output logic [6:0] o_remaining
);

  localparam logic [6:0] NC   = 7'(NUM_CARDS);
  localparam logic [6:0] HS   = 7'(HAND_SIZE);
  localparam logic [2:0] MAXP = 3'(MAX_PLAYERS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEAL,
    S_FLIP,
    S_SERVE,
    S_DRAW
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] ptr_q, ptr_d;
  logic [2:0] np_q, np_d;
  logic [1:0] pl_q, pl_d;
  logic [1:0] dpl_q, dpl_d;
  logic [2:0] cnt_q, cnt_d;
  logic [5:0] top_q, top_d;
  logic       topv_q, topv_d;
  logic       short_q, short_d;
  logic [6:0] rem_q, rem_d;
  logic       empty_q, empty_d;

  logic [5:0] card_raw;
  logic       card_valid;
  logic       hs;
  logic [6:0] deal_tot;
  logic       deal_last;
  logic       draw_last;
  logic       at_end;
  logic [2:0] np_clamp;
  logic [2:0] cnt_clamp;

  // Pointer may sit one past the last card once the deck is exhausted.
  assign at_end   = (ptr_q == NC);
  assign card_raw = at_end ? 6'd0 : i_deck[ptr_q];

  // Dropping i_deck_valid aborts, so no transfer is offered that cycle.
  assign card_valid = i_deck_valid &&
                      (state_q == S_DEAL || state_q == S_DRAW);
  assign hs         = card_valid && i_card_ready;

  assign deal_tot  = 7'(np_q) * HS;
  assign deal_last = (ptr_q == deal_tot - 7'd1);
  assign draw_last = (cnt_q == 3'd1) || (ptr_q == NC - 7'd1);

  assign np_clamp = (i_num_players < 3'd2) ? 3'd2 :
                    (i_num_players > MAXP) ? MAXP :
                    i_num_players;
  assign cnt_clamp = (i_draw_cnt > 3'd4) ? 3'd4 : i_draw_cnt;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    np_d    = np_q;
    pl_d    = pl_q;
    dpl_d   = dpl_q;
    cnt_d   = cnt_q;
    top_d   = top_q;
    topv_d  = topv_q;
    short_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start && i_deck_valid) begin
          state_d = S_DEAL;
          np_d    = np_clamp;
          ptr_d   = 7'd0;
          pl_d    = 2'd0;
          topv_d  = 1'b0;
        end
      end
      S_DEAL: begin
        if (hs) begin
          ptr_d = ptr_q + 7'd1;
          if ({1'b0, pl_q} == np_q - 3'd1) begin
            pl_d = 2'd0;
          end else begin
            pl_d = pl_q + 2'd1;
          end
          if (deal_last) begin
            state_d = S_FLIP;
          end
        end
      end
      S_FLIP: begin
        if (at_end) begin
          state_d = S_SERVE;
          topv_d  = 1'b0;
        end else begin
          ptr_d = ptr_q + 7'd1;
          // A wild+4 cannot open the discard pile; bury it and retry.
          if (card_raw[3:0] == 4'd14) begin
            if (ptr_q == NC - 7'd1) begin
              state_d = S_SERVE;
              topv_d  = 1'b0;
            end
          end else begin
            top_d   = card_raw;
            topv_d  = 1'b1;
            state_d = S_SERVE;
          end
        end
      end
      S_SERVE: begin
        if (i_draw_req && i_draw_cnt != 3'd0) begin
          dpl_d = i_draw_player;
          cnt_d = cnt_clamp;
          if (at_end) begin
            short_d = 1'b1;
          end else begin
            state_d = S_DRAW;
          end
        end
      end
      S_DRAW: begin
        if (hs) begin
          ptr_d = ptr_q + 7'd1;
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = S_SERVE;
          end else if (ptr_q == NC - 7'd1) begin
            state_d = S_SERVE;
            short_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_q != S_IDLE && !i_deck_valid) begin
      state_d = S_IDLE;
      ptr_d   = ptr_q;
      topv_d  = 1'b0;
      short_d = 1'b0;
    end
  end

  assign rem_d   = NC - ptr_d;
  assign empty_d = (ptr_d == NC);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 7'd0;
      np_q    <= 3'd2;
      pl_q    <= 2'd0;
      dpl_q   <= 2'd0;
      cnt_q   <= 3'd0;
      top_q   <= 6'd0;
      topv_q  <= 1'b0;
      short_q <= 1'b0;
      rem_q   <= NC;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      np_q    <= np_d;
      pl_q    <= pl_d;
      dpl_q   <= dpl_d;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
      topv_q  <= topv_d;
      short_q <= short_d;
      rem_q   <= rem_d;
      empty_q <= empty_d;
    end
  end

  assign o_card       = card_valid ? card_raw : 6'd0;
  assign o_card_valid = card_valid;
  assign o_player     = !card_valid ? 2'd0 :
                        (state_q == S_DEAL) ? pl_q : dpl_q;
  assign o_last       = card_valid &&
                        ((state_q == S_DEAL) ? deal_last : draw_last);
  assign o_top_card   = top_q;
  assign o_top_valid  = topv_q;
  assign o_busy       = (state_q == S_DEAL) || (state_q == S_FLIP) ||
                        (state_q == S_DRAW);
  assign o_empty      = empty_q;
  assign o_short      = short_q;
  assign o_remaining  = rem_q;

endmodule

// File: tb/tb_deck_dealer.sv
// tb_deck_dealer: directed scenario tests for deck_dealer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_deck_dealer;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] deck [107:0];
  logic       dv;
  logic       start;
  logic [2:0] np;
  logic       req;
  logic [1:0] dpl;
  logic [2:0] dcnt;
  logic       ready;
  logic [5:0] o_card;
  logic       o_card_valid;
  logic [1:0] o_player;
  logic       o_last;
  logic [5:0] o_top_card;
  logic       o_top_valid;
  logic       o_busy;
  logic       o_empty;
  logic       o_short;
  logic [6:0] o_remaining;

  int passed = 0;
  int total  = 0;
  int eptr   = 0;

  always #5 clk = ~clk;

  deck_dealer dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_deck        (deck),
    .i_deck_valid  (dv),
    .i_start       (start),
    .i_num_players (np),
    .i_draw_req    (req),
    .i_draw_player (dpl),
    .i_draw_cnt    (dcnt),
    .i_card_ready  (ready),
    .o_card        (o_card),
    .o_card_valid  (o_card_valid),
    .o_player      (o_player),
    .o_last        (o_last),
    .o_top_card    (o_top_card),
    .o_top_valid   (o_top_valid),
    .o_busy        (o_busy),
    .o_empty       (o_empty),
    .o_short       (o_short),
    .o_remaining   (o_remaining)
  );

  task automatic test_reset();
    rst = 1'b1; dv = 1'b0; start = 1'b0; np = 3'd4;
    req = 1'b0; dpl = 2'd0; dcnt = 3'd0; ready = 1'b1;
    for (int k = 0; k < 108; k++) deck[k] = 6'(k);
    repeat (2) @(negedge clk);
    total++;
    if (o_remaining !== 7'd108 || o_empty !== 1'b0) begin
      $display("FAIL reset_rem: rem=%0d empty=%0d required rem=108 empty=0",
               o_remaining, o_empty);
    end else passed++;
    total++;
    if (o_card_valid !== 1'b0 || o_busy !== 1'b0 || o_top_valid !== 1'b0 ||
        o_short !== 1'b0 || o_card !== 6'd0 || o_last !== 1'b0) begin
      $display("FAIL reset_out: valid=%0d busy=%0d topv=%0d short=%0d card=%0d required all 0",
               o_card_valid, o_busy, o_top_valid, o_short, o_card);
    end else passed++;
    rst = 1'b0; dv = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_deal(input logic [2:0] np_in, input int exp_np,
                           input bit tog, input logic [5:0] exp_top,
                           input logic [6:0] exp_rem, input string nm);
    int k, cyc, tot;
    bit held;
    logic [5:0] hc;
    logic [1:0] hp;
    logic hl;
    tot = exp_np * 7;
    np = np_in; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0; cyc = 0; held = 1'b0;
    hc = 6'd0; hp = 2'd0; hl = 1'b0;
    while (k < tot && cyc < 400) begin
      ready = tog ? 1'(cyc % 2) : 1'b1;
      if (o_card_valid) begin
        if (held) begin
          total++;
          if (o_card !== hc || o_player !== hp || o_last !== hl) begin
            $display("FAIL %s_stall: card=%0d player=%0d last=%0d required card=%0d player=%0d last=%0d",
                     nm, o_card, o_player, o_last, hc, hp, hl);
          end else passed++;
        end
        if (ready) begin
          total++;
          if (o_card !== deck[k] || o_player !== 2'(k % exp_np) ||
              o_last !== 1'(k == tot - 1) || o_busy !== 1'b1) begin
            $display("FAIL %s_card%0d: card=%0d player=%0d last=%0d busy=%0d required card=%0d player=%0d last=%0d busy=1",
                     nm, k, o_card, o_player, o_last, o_busy, deck[k],
                     k % exp_np, k == tot - 1);
          end else passed++;
          k++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hc = o_card; hp = o_player; hl = o_last;
        end
      end
      @(negedge clk);
      cyc++;
    end
    ready = 1'b1;
    total++;
    if (k != tot) begin
      $display("FAIL %s_count: cards=%0d required %0d", nm, k, tot);
    end else passed++;
    cyc = 0;
    while (o_busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (o_busy !== 1'b0 || o_top_valid !== 1'b1 || o_top_card !== exp_top) begin
      $display("FAIL %s_top: busy=%0d topv=%0d top=%0d required busy=0 topv=1 top=%0d",
               nm, o_busy, o_top_valid, o_top_card, exp_top);
    end else passed++;
    total++;
    if (o_remaining !== exp_rem || o_empty !== 1'b0) begin
      $display("FAIL %s_rem: rem=%0d empty=%0d required rem=%0d empty=0",
               nm, o_remaining, o_empty, exp_rem);
    end else passed++;
  endtask

  task automatic test_abort(input logic [6:0] exp_rem, input logic exp_empty);
    dv = 1'b0;
    @(negedge clk);
    dv = 1'b1;
    total++;
    if (o_busy !== 1'b0 || o_card_valid !== 1'b0 || o_top_valid !== 1'b0 ||
        o_remaining !== exp_rem || o_empty !== exp_empty) begin
      $display("FAIL abort: busy=%0d valid=%0d topv=%0d rem=%0d empty=%0d required 0 0 0 %0d %0d",
               o_busy, o_card_valid, o_top_valid, o_remaining, o_empty,
               exp_rem, exp_empty);
    end else passed++;
  endtask

  task automatic test_draw(input logic [1:0] pl, input logic [2:0] c,
                           input int exp_n, input bit exp_short,
                           input string nm);
    int n, cyc;
    req = 1'b1; dpl = pl; dcnt = c;
    @(negedge clk);
    req = 1'b0;
    n = 0; cyc = 0;
    while (n < exp_n && cyc < 50) begin
      if (o_card_valid) begin
        total++;
        if (o_card !== deck[eptr] || o_player !== pl ||
            o_last !== 1'(n == exp_n - 1) || o_busy !== 1'b1) begin
          $display("FAIL %s_card%0d: card=%0d player=%0d last=%0d busy=%0d required card=%0d player=%0d last=%0d busy=1",
                   nm, n, o_card, o_player, o_last, o_busy, deck[eptr], pl,
                   n == exp_n - 1);
        end else passed++;
        eptr++;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (n != exp_n) begin
      $display("FAIL %s_count: cards=%0d required %0d", nm, n, exp_n);
    end else passed++;
    total++;
    if (o_busy !== 1'b0 || o_short !== exp_short || o_card_valid !== 1'b0 ||
        o_remaining !== 7'(108 - eptr) || o_empty !== 1'(eptr == 108)) begin
      $display("FAIL %s_end: busy=%0d short=%0d valid=%0d rem=%0d empty=%0d required 0 %0d 0 %0d %0d",
               nm, o_busy, o_short, o_card_valid, o_remaining, o_empty,
               exp_short, 108 - eptr, eptr == 108);
    end else passed++;
    @(negedge clk);
    total++;
    if (o_short !== 1'b0) begin
      $display("FAIL %s_shortclr: short=%0d required 0", nm, o_short);
    end else passed++;
  endtask

  task automatic test_draw_zero();
    req = 1'b1; dpl = 2'd1; dcnt = 3'd0;
    @(negedge clk);
    req = 1'b0;
    total++;
    if (o_busy !== 1'b0 || o_card_valid !== 1'b0 || o_short !== 1'b0 ||
        o_remaining !== 7'(108 - eptr)) begin
      $display("FAIL draw_zero: busy=%0d valid=%0d short=%0d rem=%0d required 0 0 0 %0d",
               o_busy, o_card_valid, o_short, o_remaining, 108 - eptr);
    end else passed++;
  endtask

  task automatic test_drain();
    int n;
    while (eptr < 106) begin
      n = (106 - eptr > 4) ? 4 : 106 - eptr;
      test_draw(2'd0, 3'(n), n, 1'b0, "drain");
    end
  endtask

  task automatic test_empty_req();
    req = 1'b1; dpl = 2'd3; dcnt = 3'd2;
    @(negedge clk);
    req = 1'b0;
    total++;
    if (o_short !== 1'b1 || o_card_valid !== 1'b0 || o_busy !== 1'b0) begin
      $display("FAIL empty_req: short=%0d valid=%0d busy=%0d required 1 0 0",
               o_short, o_card_valid, o_busy);
    end else passed++;
    @(negedge clk);
    total++;
    if (o_short !== 1'b0 || o_card_valid !== 1'b0) begin
      $display("FAIL empty_req_clr: short=%0d valid=%0d required 0 0",
               o_short, o_card_valid);
    end else passed++;
  endtask

  task automatic test_start_no_deck();
    dv = 1'b0; start = 1'b1; np = 3'd4;
    @(negedge clk);
    start = 1'b0; dv = 1'b1;
    @(negedge clk);
    total++;
    if (o_busy !== 1'b0 || o_card_valid !== 1'b0 || o_remaining !== 7'd0) begin
      $display("FAIL start_no_deck: busy=%0d valid=%0d rem=%0d required 0 0 0",
               o_busy, o_card_valid, o_remaining);
    end else passed++;
  endtask

  task automatic test_rst_mid_deal();
    np = 3'd3; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (o_card_valid !== 1'b1 || o_player !== 2'd2 || o_card !== 6'd5) begin
      $display("FAIL mid_deal: valid=%0d player=%0d card=%0d required 1 2 5",
               o_card_valid, o_player, o_card);
    end else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (o_remaining !== 7'd108 || o_card_valid !== 1'b0 || o_busy !== 1'b0 ||
        o_top_valid !== 1'b0 || o_empty !== 1'b0 || o_card !== 6'd0) begin
      $display("FAIL rst_mid: rem=%0d valid=%0d busy=%0d topv=%0d empty=%0d card=%0d required 108 0 0 0 0 0",
               o_remaining, o_card_valid, o_busy, o_top_valid, o_empty, o_card);
    end else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (o_busy !== 1'b0 || o_card_valid !== 1'b0) begin
      $display("FAIL rst_idle: busy=%0d valid=%0d required 0 0",
               o_busy, o_card_valid);
    end else passed++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_deal(3'd4, 4, 1'b0, 6'd28, 7'd79, "deal4");
    test_abort(7'd79, 1'b0);
    test_deal(3'd4, 4, 1'b1, 6'd28, 7'd79, "deal_stall");
    test_abort(7'd79, 1'b0);
    deck[15] = 6'h0E;
    test_deal(3'd2, 2, 1'b0, 6'd16, 7'd91, "deal2_skip");
    eptr = 17;
    test_draw(2'd2, 3'd4, 4, 1'b0, "draw4");
    test_draw(2'd1, 3'd7, 4, 1'b0, "draw_clamp");
    test_draw_zero();
    test_drain();
    test_draw(2'd3, 3'd4, 2, 1'b1, "draw_short");
    test_empty_req();
    test_abort(7'd0, 1'b1);
    test_start_no_deck();
    test_deal(3'd7, 4, 1'b0, 6'd28, 7'd79, "deal_np7");
    test_abort(7'd79, 1'b0);
    test_rst_mid_deal();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
